// File: rtl/pe_pkg.sv
// Shared definitions for the PE input path (input FIFO and PE arbiter).
//   PE_DATA_W     : work-item width shared by the FIFO and the arbiter
//   PE_FIFO_DEPTH : default input FIFO depth
//   ptr_w()       : pointer width for a given depth
//   cnt_w()       : occupancy-count width for a given depth (holds 0..depth)
package pe_pkg;

    localparam int PE_DATA_W     = 16;
    localparam int PE_FIFO_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_storage.sv
// DEPTH x WIDTH register array for the PE input FIFO.
//   clock, reset : rising-edge clock, asynchronous active-low clear
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
module fifo_storage
    import pe_pkg::*;
#(
    parameter int  WIDTH = PE_DATA_W,
    parameter int  DEPTH = PE_FIFO_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we && waddr == AW'(i)) mem_q[i] <= wdata;
            end
        end
    end

    // Compare-based mux so an address beyond DEPTH-1 (non-power-of-two
    // depth) can never select a nonexistent row; such codes read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) rdata = mem_q[i];
        end
    end

endmodule

// File: rtl/pe_input_fifo.sv
// First-word-fall-through input FIFO feeding the PE arbiter.
//   clock, reset              : rising-edge clock, asynchronous active-low reset
//   io_enq_valid/ready/data   : producer side
//   io_deq_valid/ready/data   : consumer side (arbiter io_fifo_*)
//   io_count/io_full/io_empty : registered occupancy status
// Outputs depend only on registers, so there is no combinational path
// from any input to any output.
module pe_input_fifo
    import pe_pkg::*;
#(
    parameter int  WIDTH = PE_DATA_W,
    parameter int  DEPTH = PE_FIFO_DEPTH,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_data,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_data,
    output logic [CW-1:0]    io_count,
    output logic             io_full,
    output logic             io_empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          enq_fire, deq_fire;

    // Explicit wrap so non-power-of-two depths cycle 0..DEPTH-1.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign io_full      = (count_q == CW'(DEPTH));
    assign io_empty     = (count_q == '0);
    assign io_enq_ready = !io_full;
    assign io_deq_valid = !io_empty;
    assign io_count     = count_q;

    assign enq_fire = io_enq_valid & io_enq_ready;
    assign deq_fire = io_deq_valid & io_deq_ready;

    always_comb begin
        wr_ptr_d = enq_fire ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq_fire ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clock (clock),
        .reset (reset),
        .we    (enq_fire),
        .waddr (wr_ptr_q),
        .wdata (io_enq_data),
        .raddr (rd_ptr_q),
        .rdata (io_deq_data)
    );

endmodule

// File: tb/tb_pe_input_fifo.sv
// Bench for pe_input_fifo: a DEPTH=8 instance driven by directed vectors
// and a DEPTH=5 instance driven by random valid/ready, both checked every
// cycle against queue models, plus literal expectations at key points.
module tb_pe_input_fifo;

    localparam int W = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // DEPTH = 8 instance
    logic          a_ev = 1'b0, a_dr = 1'b0;
    logic [W-1:0]  a_ed = '0;
    logic          a_er, a_dv, a_full, a_empty;
    logic [W-1:0]  a_dd;
    logic [3:0]    a_cnt;

    // DEPTH = 5 instance
    logic          b_ev = 1'b0, b_dr = 1'b0;
    logic [W-1:0]  b_ed = '0;
    logic          b_er, b_dv, b_full, b_empty;
    logic [W-1:0]  b_dd;
    logic [2:0]    b_cnt;

    pe_input_fifo #(.WIDTH(W), .DEPTH(8)) dut_a (
        .clock(clock), .reset(reset),
        .io_enq_valid(a_ev), .io_enq_ready(a_er), .io_enq_data(a_ed),
        .io_deq_valid(a_dv), .io_deq_ready(a_dr), .io_deq_data(a_dd),
        .io_count(a_cnt), .io_full(a_full), .io_empty(a_empty)
    );

    pe_input_fifo #(.WIDTH(W), .DEPTH(5)) dut_b (
        .clock(clock), .reset(reset),
        .io_enq_valid(b_ev), .io_enq_ready(b_er), .io_enq_data(b_ed),
        .io_deq_valid(b_dv), .io_deq_ready(b_dr), .io_deq_data(b_dd),
        .io_count(b_cnt), .io_full(b_full), .io_empty(b_empty)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: plain queues, plus the slot index each side of the
    // DEPTH=5 FIFO must be on (number of transfers modulo 5).
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           b_wp = 0, b_rp = 0;
    int           b_wraps = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            qa.delete();
            qb.delete();
            b_wp = 0;
            b_rp = 0;
        end else begin
            bit ea, da, eb, db;
            ea = a_ev && (qa.size() < 8);
            da = a_dr && (qa.size() > 0);
            eb = b_ev && (qb.size() < 5);
            db = b_dr && (qb.size() > 0);
            if (da) void'(qa.pop_front());
            if (ea) qa.push_back(a_ed);
            if (db) void'(qb.pop_front());
            if (eb) qb.push_back(b_ed);
            if (eb) begin
                if (b_wp == 4) b_wraps++;
                b_wp = (b_wp + 1) % 5;
            end
            if (db) b_rp = (b_rp + 1) % 5;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        chk("a_count", a_cnt, qa.size());
        chk("a_empty", a_empty, qa.size() == 0);
        chk("a_full", a_full, qa.size() == 8);
        chk("a_enq_ready", a_er, qa.size() < 8);
        chk("a_deq_valid", a_dv, qa.size() > 0);
        chk("a_data_known", $isunknown(a_dd), 0);
        if (qa.size() > 0) chk("a_deq_data", a_dd, qa[0]);
        chk("b_count", b_cnt, qb.size());
        chk("b_empty", b_empty, qb.size() == 0);
        chk("b_full", b_full, qb.size() == 5);
        chk("b_enq_ready", b_er, qb.size() < 5);
        chk("b_deq_valid", b_dv, qb.size() > 0);
        chk("b_data_known", $isunknown(b_dd), 0);
        if (qb.size() > 0) chk("b_deq_data", b_dd, qb[0]);
        chk("b_wr_ptr", dut_b.wr_ptr_q, b_wp);
        chk("b_rd_ptr", dut_b.rd_ptr_q, b_rp);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic [W-1:0] exp_seq [4];
        // Reset values while reset is held
        #1;
        chk("rst_enq_ready", a_er, 1);
        chk("rst_deq_valid", a_dv, 0);
        chk("rst_deq_data", a_dd, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_full", a_full, 0);
        chk("rst_empty", a_empty, 1);
        step();
        reset = 1'b1;
        step();

        // Fill 1..8 with no dequeue, then a refused 9th offer
        for (int i = 1; i <= 8; i++) begin
            a_ev = 1'b1;
            a_ed = W'(i);
            step();
        end
        chk("fill_full", a_full, 1);
        chk("fill_enq_ready", a_er, 0);
        chk("fill_count", a_cnt, 8);
        a_ed = 16'h0009;
        step();
        chk("fill_9th_refused", a_cnt, 8);
        a_ev = 1'b0;

        // Drain in order
        a_dr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", a_dv, 1);
            chk("drain_data", a_dd, i);
            step();
        end
        chk("drain_empty", a_empty, 1);
        a_dr = 1'b0;

        // First-word latency
        a_ev = 1'b1;
        a_ed = 16'hBEEF;
        chk("lat_not_before", a_dv, 0);
        step();
        a_ev = 1'b0;
        chk("lat_valid", a_dv, 1);
        chk("lat_data", a_dd, 16'hBEEF);
        a_dr = 1'b1;
        step();
        a_dr = 1'b0;

        // Simultaneous enqueue/dequeue at count 4
        for (int i = 0; i < 4; i++) begin
            a_ev = 1'b1;
            a_ed = W'(16'h0010 + i);
            step();
        end
        chk("sim_pre_count", a_cnt, 4);
        a_ed = 16'hA5A5;
        a_dr = 1'b1;
        step();
        a_ev = 1'b0;
        chk("sim_count_holds", a_cnt, 4);
        exp_seq[0] = 16'h0011; exp_seq[1] = 16'h0012;
        exp_seq[2] = 16'h0013; exp_seq[3] = 16'hA5A5;
        for (int k = 0; k < 4; k++) begin
            chk("sim_order", a_dd, exp_seq[k]);
            step();
        end
        a_dr = 1'b0;
        chk("sim_empty", a_empty, 1);

        // Full with simultaneous dequeue
        for (int i = 0; i < 8; i++) begin
            a_ev = 1'b1;
            a_ed = W'(16'h0020 + i);
            step();
        end
        a_ed = 16'h0030;
        a_dr = 1'b1;
        step();
        chk("full_deq_c1_count", a_cnt, 7);
        chk("full_deq_c1_head", a_dd, 16'h0021);
        step();
        a_ev = 1'b0;
        chk("full_deq_c2_count", a_cnt, 7);
        chk("full_deq_c2_head", a_dd, 16'h0022);
        for (int i = 0; i < 7; i++) step();
        a_dr = 1'b0;
        chk("full_deq_empty", a_empty, 1);

        // DEPTH=5 random traffic
        for (int i = 0; i < 200; i++) begin
            b_ev = ($urandom_range(0, 9) < 6);
            b_dr = ($urandom_range(0, 9) < 5);
            b_ed = W'($urandom);
            step();
        end
        b_ev = 1'b0;
        b_dr = 1'b1;
        for (int i = 0; i < 6; i++) step();
        b_dr = 1'b0;
        chk("b_drained", b_empty, 1);
        chk("b_wrapped", b_wraps >= 2, 1);

        // Reset mid-stream with count 3
        for (int i = 0; i < 3; i++) begin
            a_ev = 1'b1;
            a_ed = W'(16'h0040 + i);
            step();
        end
        a_ev = 1'b0;
        chk("mid_pre_count", a_cnt, 3);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_count", a_cnt, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_deq_valid", a_dv, 0);
        chk("mid_rst_enq_ready", a_er, 1);
        chk("mid_rst_deq_data", a_dd, 0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_empty", a_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_input_fifo.md
# pe_input_fifo

Synchronous first-word-fall-through FIFO that buffers 16-bit work items and presents them through a valid/ready port to the PE arbiter. It is the stage directly upstream of the arbiter. Its dequeue port drives the arbiter's `io_fifo_valid`, `io_fifo_data` and `io_fifo_ready` signals. It decouples the bursty producer from the two processing elements and reports occupancy for flow-control monitoring.

## Interface
Parameters:
- `WIDTH`, 16: data width in bits; must match the arbiter's data width.
- `DEPTH`, 8: number of entries, minimum 2; need not be a power of two.
- `CW`, derived as clog2(DEPTH+1): width of the occupancy count.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to `clock` upstream of this block.
- `io_enq_valid`  in  1  producer offers `io_enq_data`.
- `io_enq_ready`  out  1  FIFO can accept an entry this cycle.
- `io_enq_data`  in  WIDTH  entry to write.
- `io_deq_valid`  out  1  head entry present; connects to arbiter `io_fifo_valid`.
- `io_deq_ready`  in  1  consumer takes the head; connects from arbiter `io_fifo_ready`.
- `io_deq_data`  out  WIDTH  head entry; connects to arbiter `io_fifo_data`.
- `io_count`  out  CW  current number of stored entries, 0..DEPTH.
- `io_full`  out  1  count == DEPTH.
- `io_empty`  out  1  count == 0.

## Operation
- State consists of the following, all of which is cleared to 0 by reset:
  - storage array of DEPTH x WIDTH registers;
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each clog2(DEPTH) bits;
  - occupancy register `count`, CW bits.
- Enqueue fire = `io_enq_valid & io_enq_ready`. On fire, write `io_enq_data` to storage[`wr_ptr`] and advance `wr_ptr`.
- Dequeue fire = `io_deq_valid & io_deq_ready`. On fire, advance `rd_ptr`.
- Pointer advance: if the pointer equals DEPTH-1 it goes to 0, otherwise it increments by 1. The wrap is an explicit compare, not a modulo-2^n overflow.
- Count update:
  - enqueue only: +1;
  - dequeue only: -1;
  - both or neither: unchanged.
- Output decode:
  - `io_enq_ready` = !full. It does not depend on `io_deq_ready`; there is no write-through when full.
  - `io_deq_valid` = !empty.
  - `io_deq_data` = storage[`rd_ptr`], a combinational read.
- `io_deq_data` is undefined to the consumer whenever `io_deq_valid` = 0, but it must be a stable register value, never X.
- Boundary conditions:
  - Full: enqueue is refused. A simultaneous dequeue frees the slot for the following cycle only.
  - Empty: dequeue cannot fire. A simultaneous enqueue is not bypassed to the output.
  - Simultaneous enqueue and dequeue at 0 < count < DEPTH: both pointers advance and count holds.
  - Wrap: both pointers independently wrap from DEPTH-1 to 0. With DEPTH=5 the sequence is 3, 4, 0, 1.
  - Reset mid-operation: every stored entry is discarded and the outputs take their reset values within the same cycle.
- `io_deq_valid` and `io_deq_data` must stay stable while `io_deq_ready` is low. The arbiter relies on this.

## Timing
- Reset values:
  - `io_enq_ready` = 1;
  - `io_deq_valid` = 0;
  - `io_deq_data` = 0;
  - `io_count` = 0;
  - `io_full` = 0;
  - `io_empty` = 1.
- Latency: an entry enqueued at edge N appears on the dequeue port in the cycle after edge N. This is 1 cycle minimum, with no combinational path from the enqueue inputs to the dequeue outputs.
- No combinational path from `io_deq_ready` to `io_enq_ready`, or from `io_enq_valid` to `io_deq_valid`.
- Sustained throughput: 1 entry/cycle in each direction while 0 < count < DEPTH.
- `io_count`, `io_full` and `io_empty` are decoded directly from registers; they reflect the state after the last edge.

## Structure
- Shared package `pe_pkg`:
  - `PE_DATA_W` = 16, used by both the FIFO and the arbiter;
  - the pointer-width and count-width helper functions;
  - the default FIFO depth constant.
- One sub-module `fifo_storage`: DEPTH x WIDTH register array with one synchronous write port (`we`, `waddr`, `wdata`), one asynchronous read port (`raddr`, `rdata`), and asynchronous active-low clear.
- Pointer, count and flag logic lives in `pe_input_fifo` itself.

## Test plan
- Reset and idle: assert `reset` low mid-stream with count=3 -> same cycle: count=0, `io_empty`=1, `io_deq_valid`=0, `io_enq_ready`=1, `io_deq_data`=0.
- Fill and drain, DEPTH=8:
  - enqueue 0x0001..0x0008 with `io_deq_ready`=0 -> after 8 edges `io_full`=1, `io_enq_ready`=0, and a 9th offer 0x0009 is not accepted;
  - then hold `io_deq_ready`=1 -> 0x0001..0x0008 come out in order over 8 cycles, then `io_empty`=1.
- First-word latency: enqueue 0xBEEF into an empty FIFO at edge N -> `io_deq_valid`=1 and `io_deq_data`=0xBEEF in the cycle after edge N, and not before.
- Simultaneous enqueue and dequeue at count=4: enqueue 0xA5A5 while dequeuing -> count stays 4, and 0xA5A5 is dequeued 4 dequeues later.
- Full with simultaneous dequeue: at count=8 hold `io_enq_valid`=1 and `io_deq_ready`=1 -> cycle 1: dequeue only, count=7; cycle 2: enqueue and dequeue, count=7.
- Non-power-of-two wrap, DEPTH=5: randomized valid/ready over 200 cycles -> output sequence matches a reference queue model, and both pointers wrap from 4 to 0.
